clkgen_phi2_div: RTL and testbench

//  Parametrised CPU clock (PHI2) generator, clocked by the single fast clock hsclk_in.

---
 rtl/clkgen_phi2_div.sv | 130 +++++++++++++
 tb/tb_clkgen_phi2_div.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clkgen_phi2_div.sv
// Purpose : PHI2 CPU clock generator; divides hsclk_in by a programmable
//           per-phase length and can freeze clkout high on request.
// Latency : all outputs registered except rdy; a ratio change takes effect at the next PHI2 fall.
// Backpressure: stop_req holds clkout high at the end of a high phase; rdy
//               (optional) deasserts while a requested ratio is not yet in use.
//
// Ports
//   hsclk_in      fast source clock, every state change on its rising edge
//   rst_b         asynchronous active-low reset
//   div_sel       requested phase length minus one
//   stop_req      freeze clkout high once the current high phase completes
//   clkout        generated PHI2 clock (registered, glitch-free)
//   div_selected  phase length minus one currently in use
//   stop_ack      high while clkout is frozen high
//   phi2_rise_stb one-cycle pulse on the first hsclk cycle with clkout=1
//   phi2_fall_stb one-cycle pulse on the first hsclk cycle with clkout=0
//   rdy           ratio-change handshake (see RDY_ON_DIVSW)

module clkgen_phi2_div #(
    parameter int DIV_W        = 4,
    parameter int RESET_DIV    = 3,
    parameter bit RDY_ON_DIVSW = 1'b0
) (
    input  logic             hsclk_in,
    input  logic             rst_b,
    input  logic [DIV_W-1:0] div_sel,
    input  logic             stop_req,
    output logic             clkout,
    output logic [DIV_W-1:0] div_selected,
    output logic             stop_ack,
    output logic             phi2_rise_stb,
    output logic             phi2_fall_stb,
    output logic             rdy
);

    localparam logic [DIV_W-1:0] RESET_VAL = DIV_W'(RESET_DIV);

    typedef enum logic [1:0] {
        RUN_LO  = 2'd0,
        RUN_HI  = 2'd1,
        STOPPED = 2'd2
    } state_t;

    state_t           state;
    logic [DIV_W-1:0] cnt;
    logic             phase_end;

    // The edge that observes cnt==0 is the last edge of a phase, so a phase
    // spans div_selected+1 hsclk cycles.
    assign phase_end = (cnt == '0);

    always_ff @(posedge hsclk_in or negedge rst_b) begin
        if (!rst_b) begin
            state         <= RUN_LO;
            cnt           <= RESET_VAL;
            div_selected  <= RESET_VAL;
            clkout        <= 1'b0;
            stop_ack      <= 1'b0;
            phi2_rise_stb <= 1'b0;
            phi2_fall_stb <= 1'b0;
        end else begin
            // Strobes are single-cycle; only a transition below re-arms one.
            phi2_rise_stb <= 1'b0;
            phi2_fall_stb <= 1'b0;

            case (state)
                RUN_LO: begin
                    if (phase_end) begin
                        clkout        <= 1'b1;
                        cnt           <= div_selected;
                        phi2_rise_stb <= 1'b1;
                        state         <= RUN_HI;
                    end else begin
                        cnt <= cnt - DIV_W'(1);
                    end
                end

                RUN_HI: begin
                    if (phase_end) begin
                        if (stop_req) begin
                            // Full high phase already served; park high.
                            stop_ack <= 1'b1;
                            state    <= STOPPED;
                        end else begin
                            // Cycle boundary: the only place a new ratio is
                            // adopted, so a running PHI2 cycle never changes.
                            clkout        <= 1'b0;
                            div_selected  <= div_sel;
                            cnt           <= div_sel;
                            phi2_fall_stb <= 1'b1;
                            state         <= RUN_LO;
                        end
                    end else begin
                        cnt <= cnt - DIV_W'(1);
                    end
                end

                STOPPED: begin
                    // Leaving the stop is an ordinary falling transition.
                    if (!stop_req) begin
                        clkout        <= 1'b0;
                        div_selected  <= div_sel;
                        cnt           <= div_sel;
                        phi2_fall_stb <= 1'b1;
                        stop_ack      <= 1'b0;
                        state         <= RUN_LO;
                    end
                end

                default: begin
                    // Unreachable encoding: restart a clean low phase.
                    clkout   <= 1'b0;
                    stop_ack <= 1'b0;
                    cnt      <= div_selected;
                    state    <= RUN_LO;
                end
            endcase
        end
    end

    generate
        if (RDY_ON_DIVSW) begin : g_rdy_cmp
            // Low while a requested ratio is still waiting for a fall edge.
            assign rdy = (div_sel == div_selected);
        end else begin : g_rdy_tied
            assign rdy = 1'b1;
        end
    endgenerate

endmodule

// File: tb/tb_clkgen_phi2_div.sv
module tb_clkgen_phi2_div;

    logic       hsclk_in;
    logic       rst_b;
    logic [3:0] div_sel;
    logic       stop_req;

    logic       clk0, sack0, rise0, fall0, rdy0;
    logic [3:0] dsel0;
    logic       clk1, sack1, rise1, fall1, rdy1;
    logic [3:0] dsel1;

    int errors = 0;
    int checks = 0;

    // Reference model: position within the current level, level, ratio, stop.
    logic       m_clk, m_stop, m_rise, m_fall;
    logic [3:0] m_len;
    int         m_pos;

    clkgen_phi2_div #(.DIV_W(4), .RESET_DIV(3), .RDY_ON_DIVSW(1'b0)) dut0 (
        .hsclk_in(hsclk_in), .rst_b(rst_b), .div_sel(div_sel), .stop_req(stop_req),
        .clkout(clk0), .div_selected(dsel0), .stop_ack(sack0),
        .phi2_rise_stb(rise0), .phi2_fall_stb(fall0), .rdy(rdy0));

    clkgen_phi2_div #(.DIV_W(4), .RESET_DIV(3), .RDY_ON_DIVSW(1'b1)) dut1 (
        .hsclk_in(hsclk_in), .rst_b(rst_b), .div_sel(div_sel), .stop_req(stop_req),
        .clkout(clk1), .div_selected(dsel1), .stop_ack(sack1),
        .phi2_rise_stb(rise1), .phi2_fall_stb(fall1), .rdy(rdy1));

    initial begin
        hsclk_in = 1'b0;
        forever #5 hsclk_in = ~hsclk_in;
    end

    function automatic logic [17:0] obs();
        return {clk0, dsel0, sack0, rise0, fall0, rdy0,
                clk1, dsel1, sack1, rise1, fall1, rdy1};
    endfunction

    function automatic logic [17:0] expv();
        return {m_clk, m_len, m_stop, m_rise, m_fall, 1'b1,
                m_clk, m_len, m_stop, m_rise, m_fall, (div_sel == m_len)};
    endfunction

    task automatic model_reset();
        m_clk  = 1'b0;
        m_stop = 1'b0;
        m_rise = 1'b0;
        m_fall = 1'b0;
        m_len  = 4'd3;
        m_pos  = 1;
    endtask

    // One hsclk edge: a level lasts m_len+1 cycles; the stop is only taken
    // where a high level would otherwise end.
    task automatic model_step();
        if (!rst_b) return;
        m_rise = 1'b0;
        m_fall = 1'b0;
        if (m_stop) begin
            if (!stop_req) begin
                m_stop = 1'b0; m_clk = 1'b0; m_len = div_sel; m_pos = 1; m_fall = 1'b1;
            end
        end else if (m_pos == int'(m_len) + 1) begin
            if (!m_clk) begin
                m_clk = 1'b1; m_pos = 1; m_rise = 1'b1;
            end else if (stop_req) begin
                m_stop = 1'b1;
            end else begin
                m_clk = 1'b0; m_len = div_sel; m_pos = 1; m_fall = 1'b1;
            end
        end else begin
            m_pos++;
        end
    endtask

    // Advance one edge; returns 1 ns after the edge with outputs settled.
    task automatic tick();
        @(posedge hsclk_in);
        model_step();
        #1;
    endtask

    // Tick until the chosen DUT strobe fires; ok=0 if the bound expires.
    task automatic wait_strobe(input bit want_rise, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            tick();
            if (want_rise ? rise0 : fall0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Shared by both reset scenarios: 4 low / 4 high from release.
    task automatic check_restart(input string name);
        for (int k = 1; k <= 16; k++) begin
            tick();
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL %s_model k=%0d got=%h exp=%h", name, k, obs(), expv());
            end
            checks++;
            if (clk0 !== 1'(((k / 4) % 2)) || rise0 !== (k % 8 == 4) || fall0 !== (k % 8 == 0)) begin
                errors++;
                $display("FAIL %s_pattern k=%0d got clk=%b rise=%b fall=%b exp clk=%0d rise=%0d fall=%0d",
                         name, k, clk0, rise0, fall0, (k / 4) % 2, k % 8 == 4, k % 8 == 0);
            end
        end
    endtask

    task automatic test_reset();
        stop_req = 1'b0;
        div_sel  = 4'd3;
        rst_b    = 1'b0;
        model_reset();
        repeat (2) @(posedge hsclk_in);
        #1;
        checks++;
        if (clk0 !== 1'b0 || dsel0 !== 4'd3 || sack0 !== 1'b0 || rise0 !== 1'b0 || fall0 !== 1'b0 || rdy1 !== 1'b1) begin
            errors++;
            $display("FAIL reset_state got clk=%b dsel=%0d sack=%b rise=%b fall=%b rdy1=%b exp 0 3 0 0 0 1",
                     clk0, dsel0, sack0, rise0, fall0, rdy1);
        end
        rst_b = 1'b1;
        check_restart("reset");
    endtask

    task automatic test_div0();
        bit   ok;
        logic prev;
        div_sel = 4'd0;
        wait_strobe(1'b0, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL div0_wait got=no_fall exp=fall"); end
        for (int k = 0; k < 12; k++) begin
            prev = clk0;
            tick();
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL div0_model k=%0d got=%h exp=%h", k, obs(), expv());
            end
            checks++;
            if (clk0 !== ~prev || rise0 !== clk0 || fall0 !== ~clk0) begin
                errors++;
                $display("FAIL div0_toggle k=%0d got clk=%b rise=%b fall=%b exp clk=%b", k, clk0, rise0, fall0, ~prev);
            end
        end
    endtask

    task automatic test_midchange();
        bit ok;
        div_sel = 4'd1;
        wait_strobe(1'b0, ok);
        wait_strobe(1'b1, ok);
        checks++;
        if (!ok || dsel0 !== 4'd1) begin
            errors++;
            $display("FAIL mid_setup got ok=%b dsel=%0d exp ok=1 dsel=1", ok, dsel0);
        end
        div_sel = 4'd3;
        tick();
        tick();
        checks++;
        if (clk0 !== 1'b0 || fall0 !== 1'b1 || dsel0 !== 4'd3 || dsel1 !== 4'd3) begin
            errors++;
            $display("FAIL mid_fall got clk=%b fall=%b dsel=%0d exp 0 1 3", clk0, fall0, dsel0);
        end
        for (int k = 1; k <= 12; k++) begin
            tick();
            checks++;
            if (obs() !== expv() || clk0 !== 1'((k % 8) >= 4)) begin
                errors++;
                $display("FAIL mid_after k=%0d got=%h exp=%h clk_exp=%0d", k, obs(), expv(), (k % 8) >= 4);
            end
        end
    endtask

    task automatic test_stop();
        bit ok;
        div_sel = 4'd3;
        wait_strobe(1'b0, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL stop_wait got=no_fall exp=fall"); end
        stop_req = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            tick();
            checks++;
            if (obs() !== expv() || clk0 !== (k >= 4) || sack0 !== (k >= 8) || fall0 !== 1'b0) begin
                errors++;
                $display("FAIL stop_hold k=%0d got clk=%b sack=%b fall=%b exp clk=%0d sack=%0d fall=0",
                         k, clk0, sack0, fall0, k >= 4, k >= 8);
            end
        end
        stop_req = 1'b0;
        tick();
        checks++;
        if (obs() !== expv() || clk0 !== 1'b0 || fall0 !== 1'b1 || sack0 !== 1'b0) begin
            errors++;
            $display("FAIL stop_release got clk=%b fall=%b sack=%b exp 0 1 0", clk0, fall0, sack0);
        end
    endtask

    task automatic test_rdy();
        bit ok;
        bit seen;
        div_sel = 4'd3;
        wait_strobe(1'b0, ok);
        wait_strobe(1'b1, ok);
        div_sel = 4'd6;
        #1;
        checks++;
        if (rdy1 !== 1'b0 || rdy0 !== 1'b1) begin
            errors++;
            $display("FAIL rdy_change got rdy1=%b rdy0=%b exp 0 1", rdy1, rdy0);
        end
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (fall1) begin
                seen = 1'b1;
                break;
            end
            checks++;
            if (rdy1 !== 1'b0) begin
                errors++;
                $display("FAIL rdy_pending i=%0d got=%b exp=0", i, rdy1);
            end
        end
        checks++;
        if (!seen || rdy1 !== 1'b1 || dsel1 !== 4'd6) begin
            errors++;
            $display("FAIL rdy_after_fall got seen=%b rdy1=%b dsel=%0d exp 1 1 6", seen, rdy1, dsel1);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        div_sel = 4'd5;
        wait_strobe(1'b0, ok);
        wait_strobe(1'b1, ok);
        tick();
        stop_req = 1'b1;
        rst_b    = 1'b0;
        model_reset();
        #1;
        checks++;
        if (clk0 !== 1'b0 || sack0 !== 1'b0 || dsel0 !== 4'd3 || rise0 !== 1'b0 || fall0 !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_async got clk=%b sack=%b dsel=%0d rise=%b fall=%b exp 0 0 3 0 0",
                     clk0, sack0, dsel0, rise0, fall0);
        end
        stop_req = 1'b0;
        div_sel  = 4'd3;
        tick();
        tick();
        rst_b = 1'b1;
        check_restart("reset_mid");
    endtask

    task automatic test_random();
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 7) == 0) div_sel = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 5) == 0) stop_req = ~stop_req;
            tick();
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL random k=%0d div_sel=%0d stop_req=%b got=%h exp=%h", k, div_sel, stop_req, obs(), expv());
            end
        end
        stop_req = 1'b0;
    endtask

    initial begin
        rst_b    = 1'b0;
        div_sel  = 4'd3;
        stop_req = 1'b0;
        model_reset();
        test_reset();
        test_div0();
        test_midchange();
        test_stop();
        test_rdy();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
